// File: rtl/sample_capture_pkg.sv
// sample_capture_pkg: shared state encoding, default geometry and sample type for sample_capture
package sample_capture_pkg;
    localparam int DEPTH_DEF = 1024;
    localparam int AW_DEF = 10;
    localparam int DW_DEF = 16;
    localparam int PRE_DEF = 256;
    typedef enum logic [2:0] {IDLE, FILL, WAIT_TRIG, POST, READOUT} state_t;
    typedef logic signed [DW_DEF-1:0] sample_t;
endpackage

// File: rtl/capture_ram.sv
// capture_ram: simple dual-port DEPTH x DW RAM, one write port and one registered read port
module capture_ram #(
    parameter int DEPTH = 1024,
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/sample_capture.sv
// sample_capture: triggered circular capture with valid/ready drain; SAMPLE_CAPTURE_DECIM_EN adds input decimation
module sample_capture
    import sample_capture_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int PRE = PRE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] in_sample,
    input  logic                 in_valid,
    input  logic                 arm,
    input  logic signed [DW-1:0] trig_level,
`ifdef SAMPLE_CAPTURE_DECIM_EN
    input  logic [3:0]           decim,
`endif
    output logic                 busy,
    output logic                 triggered,
    output logic signed [DW-1:0] rd_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic                 rd_last
);
    localparam logic [AW:0] PRE_END = (AW+1)'(PRE - 1);
    localparam logic [AW:0] POST_END = (AW+1)'(DEPTH - PRE - 1);
    localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);
    state_t state;
    logic [AW-1:0] wp;
    logic [AW:0] cnt, icnt;
    logic signed [DW-1:0] prev, dout, sk_data;
    logic pend, sk_valid, hit, cap, wr, rd_en, pop;
    logic [1:0] slots;
`ifdef SAMPLE_CAPTURE_DECIM_EN
    logic [3:0] dcnt, dsel;
    assign hit = dcnt == 4'd0;
`else
    assign hit = 1'b1;
`endif
    assign cap = state == FILL || state == WAIT_TRIG || state == POST;
    assign wr = in_valid && hit && cap;
    assign pop = rd_valid && rd_ready;
    // pend counts as occupancy: its data lands in rd_data or the skid register next edge
    assign slots = 2'(rd_valid) + 2'(sk_valid) + 2'(pend);
    assign rd_en = state == READOUT && icnt != FULL && (slots - 2'(pop)) <= 2'd1;
    assign busy = state != IDLE;
    assign rd_last = rd_valid && cnt == LAST;
    capture_ram #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_ram (
        .clk(clk), .we(wr), .waddr(wp), .wdata(in_sample),
        .re(rd_en), .raddr(wp + icnt[AW-1:0]), .rdata(dout)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            triggered <= 1'b0;
            rd_valid <= 1'b0;
            rd_data <= '0;
            wp <= '0;
            cnt <= '0;
            icnt <= '0;
            pend <= 1'b0;
            sk_valid <= 1'b0;
`ifdef SAMPLE_CAPTURE_DECIM_EN
            dcnt <= '0;
            dsel <= '0;
`endif
        end else begin
            pend <= rd_en;
            if (rd_en) icnt <= icnt + ONE;
            if (wr) begin
                wp <= wp + AW'(1);
                prev <= in_sample;
            end
`ifdef SAMPLE_CAPTURE_DECIM_EN
            if (in_valid && cap) dcnt <= dcnt == dsel ? 4'd0 : dcnt + 4'd1;
`endif
            case (state)
                IDLE: if (arm) begin
                    state <= FILL;
                    cnt <= '0;
                    icnt <= '0;
`ifdef SAMPLE_CAPTURE_DECIM_EN
                    dcnt <= '0;
                    dsel <= decim;
`endif
                end
                FILL: if (wr) begin
                    cnt <= cnt == PRE_END ? '0 : cnt + ONE;
                    if (cnt == PRE_END) state <= WAIT_TRIG;
                end
                WAIT_TRIG: if (wr && prev < trig_level && in_sample >= trig_level) begin
                    state <= POST_END == '0 ? READOUT : POST;
                    cnt <= {{AW{1'b0}}, POST_END != '0};
                    triggered <= 1'b1;
                end
                POST: if (wr) begin
                    cnt <= cnt == POST_END ? '0 : cnt + ONE;
                    if (cnt == POST_END) state <= READOUT;
                end
                READOUT: if (pop) begin
                    cnt <= cnt + ONE;
                    if (cnt == LAST) begin
                        state <= IDLE;
                        triggered <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            if (!rd_valid || rd_ready) begin
                rd_valid <= sk_valid || pend;
                rd_data <= sk_valid ? sk_data : pend ? dout : rd_data;
                sk_valid <= sk_valid && pend;
                if (pend) sk_data <= dout;
            end else if (pend) begin
                sk_data <= dout;
                sk_valid <= 1'b1;
            end
        end
    end
endmodule

// File: doc/sample_capture.md
Name: sample_capture

Overview:
- Writer/capture end of the FIR sample path. Records a stream of 16-bit signed samples into an internal circular RAM; the stream comes from the sine table generator or from the FIR output.
- On a threshold-crossing trigger, it freezes a window of DEPTH samples, with PRE samples taken before the trigger.
- It then drains the window, oldest sample first, over a valid/ready read port to a monitor or UART bridge.

Parameters:
- DEPTH, 1024: capture window length in samples. Must be a power of 2.
- AW, 10: address width, equal to log2(DEPTH).
- DW, 16: sample width, two's complement.
- PRE, 256: samples retained before the trigger. Legal range 1..DEPTH-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_sample  in  DW  signed input sample.
- in_valid  in  1  in_sample is valid this cycle.
- arm  in  1  single-cycle pulse that starts a capture. Honoured only in IDLE.
- trig_level  in  DW  signed trigger threshold.
- busy  out  1  high in every state except IDLE.
- triggered  out  1  high from the trigger cycle until the return to IDLE.
- rd_data  out  DW  readout sample.
- rd_valid  out  1  rd_data is valid.
- rd_ready  in  1  consumer accepts rd_data.
- rd_last  out  1  qualifies the final (DEPTH-th) readout beat.

Behaviour:
- Reset: state=IDLE; busy, triggered, rd_valid, rd_last = 0; rd_data = 0; write pointer = 0; counters = 0. RAM contents are not cleared.
- rst mid-operation aborts to IDLE the next cycle. Any in-flight readout is dropped.
- A "write" means one accepted sample: RAM[wp] <= in_sample, then wp <= wp+1 mod DEPTH (wraps DEPTH-1 -> 0).
- IDLE: no writes. arm -> FILL; the pre-trigger counter is cleared.
- FILL: write on every in_valid. After PRE writes -> WAIT_TRIG. Trigger conditions in FILL are ignored.
- WAIT_TRIG: keep writing circularly. Register the previous valid sample (prev).
  - Trigger when in_valid and prev < trig_level and in_sample >= trig_level (signed compare, rising crossing).
  - The trigger sample itself is written. Post counter = 1; triggered <= 1 the next cycle.
  - -> POST.
  - prev is invalid after arm: the first sample in FILL primes prev and cannot trigger.
- POST: write until the post count reaches DEPTH-PRE, then -> READOUT. Start address = wp after the final write, which is the oldest sample.
- READOUT:
  - in_valid is ignored; samples are dropped.
  - Reads are issued from the start address; synchronous RAM read latency is 1 cycle.
  - rd_valid first rises 2 cycles after READOUT entry.
  - AXI-style handshake:
    - rd_data/rd_last stay stable while rd_valid && !rd_ready.
    - A beat transfers on rd_valid && rd_ready.
    - Back-to-back beats at 1/cycle are sustained when rd_ready is held high (prefetch/skid register required).
  - rd_last is asserted on beat DEPTH.
  - After the last transfer -> IDLE. busy and triggered fall the next cycle.
- arm outside IDLE: ignored.
- in_valid low: no write and no counter advance in any state.
- No trigger ever arrives: remain in WAIT_TRIG until rst.

Optional Feature:
- Macro: SAMPLE_CAPTURE_DECIM_EN.
- Defined:
  - Adds input port decim, 4 bits.
  - A "write" occurs only on every (decim+1)-th valid sample. decim=0 stores every sample.
  - The decimation counter clears on arm.
  - Trigger detection uses stored samples only.
  - decim is sampled on arm; later changes are ignored until the next arm.
- Undefined: no decim port; every valid sample is a write.

Decomposition:
- Package sample_capture_pkg holds:
  - state enum: IDLE, FILL, WAIT_TRIG, POST, READOUT (3-bit encoding);
  - default DEPTH/DW/PRE constants;
  - the signed sample typedef.
- Sub-module capture_ram:
  - simple dual-port, DEPTH x DW;
  - one write port, one synchronous read port;
  - inferrable as BRAM.

Test Plan:
- Reset mid-POST: arm, feed sine-table samples, trigger, assert rst for 1 cycle -> next cycle busy=0, triggered=0, rd_valid=0, state IDLE; a second arm completes normally.
- Basic capture:
  - stimulus: ramp in_sample = -512..+1535 step 1, every cycle valid; trig_level=0; arm pulse;
  - expect trigger on sample 0;
  - expect readout of exactly 1024 beats -256..+767 in order, rd_last only on +767.
- Trigger suppression in FILL: ramp crossing 0 within the first 100 samples -> no trigger until after 256 writes; the trigger occurs at the next rising crossing only.
- Backpressure: toggle rd_ready randomly at 50% during readout -> data sequence unchanged, no duplicates or losses, rd_data stable while stalled, 1024 transfers total.
- Wrap-around: 5000 samples of the 1024-entry sine table before the trigger -> window contents equal the table entries at the correct modular indices across the wp 1023->0 wrap.
- Decimation (SAMPLE_CAPTURE_DECIM_EN, decim=3): ramp 0..8191 step 1, trig_level=2048 -> readout values are multiples of 4, strictly +4 per beat, spanning 1024 beats.
